// File: rtl/pol_ofm_rd_server_if.sv
// Per-core point-index request / Ofm return bundle between the pooling unit and its GLB read server.
// master = pooling unit side, slave = server side.
interface pol_ofm_rd_server_if #(
    parameter int IDX_WIDTH = 10,
    parameter int DW        = 512,
    parameter int POOL_CORE = 6
);
    logic [POOL_CORE-1:0]           AddrVld;
    logic [IDX_WIDTH*POOL_CORE-1:0] Addr;
    logic [POOL_CORE-1:0]           AddrRdy;
    logic [DW*POOL_CORE-1:0]        Ofm;
    logic [POOL_CORE-1:0]           OfmVld;
    logic [POOL_CORE-1:0]           OfmRdy;

    modport master (
        output AddrVld,
        output Addr,
        output OfmRdy,
        input  AddrRdy,
        input  Ofm,
        input  OfmVld
    );

    modport slave (
        input  AddrVld,
        input  Addr,
        input  OfmRdy,
        output AddrRdy,
        output Ofm,
        output OfmVld
    );
endinterface

// File: rtl/pol_ofm_rd_server.sv
// GLB-side Ofm read server: round-robin arbitrates per-core point-index requests onto one SRAM
// read port and returns each word through a 1-deep per-core output buffer.
module pol_ofm_rd_server #(
    parameter int IDX_WIDTH       = 10,
    parameter int ACT_WIDTH       = 8,
    parameter int POOL_COMP_CORE  = 64,
    parameter int POOL_CORE       = 6,
    parameter int SRAM_ADDR_WIDTH = 12,
    parameter int CNT_WIDTH       = 15,
    localparam int DW             = ACT_WIDTH * POOL_COMP_CORE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       CCUSRV_Rst,
    input  logic                       CCUSRV_CfgVld,
    output logic                       SRVCCU_CfgRdy,
    input  logic [SRAM_ADDR_WIDTH-1:0] CCUSRV_CfgBase,
    input  logic [CNT_WIDTH-1:0]       CCUSRV_CfgNum,
    pol_ofm_rd_server_if.slave         pol,
    output logic                       SRVSRAM_RdEn,
    output logic [SRAM_ADDR_WIDTH-1:0] SRVSRAM_RdAddr,
    input  logic [DW-1:0]              SRAMSRV_RdDat
);
    localparam int PTR_W = (POOL_CORE > 1) ? $clog2(POOL_CORE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [SRAM_ADDR_WIDTH-1:0]      r_base;
    logic [CNT_WIDTH-1:0]            r_num;
    logic [CNT_WIDTH-1:0]            r_issue_cnt;
    logic [CNT_WIDTH-1:0]            w_cnt_next;
    logic [PTR_W-1:0]                r_rr_ptr;
    logic [PTR_W-1:0]                w_rr_ptr_next;
    logic                            r_inflight;
    logic [PTR_W-1:0]                r_inflight_idx;
    logic [POOL_CORE-1:0]            r_ofm_vld;
    logic [POOL_CORE-1:0][DW-1:0]    r_ofm;

    logic [POOL_CORE-1:0]            w_elig;
    logic                            w_gnt_vld;
    logic [PTR_W-1:0]                w_gnt_idx;
    logic [IDX_WIDTH-1:0]            w_sel_idx;

    // Core index reached by stepping k places past the round-robin pointer.
    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] ptr, input int k);
        int t;
        t = int'(ptr) + k;
        if (t >= POOL_CORE) begin
            t = t - POOL_CORE;
        end
        return PTR_W'(t);
    endfunction

    // A core may be granted only if its buffer will be free by the time the word returns
    // and it has no read already in flight.
    genvar gi;
    generate
        for (gi = 0; gi < POOL_CORE; gi++) begin : g_core
            assign w_elig[gi] = (r_state == ST_SERVE) & ~CCUSRV_Rst & pol.AddrVld[gi]
                              & (~r_ofm_vld[gi] | pol.OfmRdy[gi])
                              & ~(r_inflight & (r_inflight_idx == PTR_W'(gi)));
            assign pol.AddrRdy[gi] = w_gnt_vld & (w_gnt_idx == PTR_W'(gi));
        end
    endgenerate

    // Scan from the far end so the eligible core closest to the pointer wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = POOL_CORE - 1; k >= 0; k--) begin
            if (w_elig[rr_idx(r_rr_ptr, k)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = rr_idx(r_rr_ptr, k);
            end
        end
    end

    assign w_sel_idx     = pol.Addr[int'(w_gnt_idx) * IDX_WIDTH +: IDX_WIDTH];
    assign w_cnt_next    = r_issue_cnt + CNT_WIDTH'(w_gnt_vld);
    assign w_rr_ptr_next = (int'(w_gnt_idx) == POOL_CORE - 1) ? '0 : w_gnt_idx + 1'b1;

    assign SRVSRAM_RdEn   = w_gnt_vld;
    assign SRVSRAM_RdAddr = w_gnt_vld ? (r_base + SRAM_ADDR_WIDTH'(w_sel_idx)) : '0;
    assign SRVCCU_CfgRdy  = (r_state == ST_IDLE);
    assign pol.OfmVld     = r_ofm_vld;
    assign pol.Ofm        = r_ofm;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (CCUSRV_CfgVld) begin
                    w_state_next = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (w_cnt_next >= r_num) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (~|r_ofm_vld && !r_inflight) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_base         <= '0;
            r_num          <= '0;
            r_issue_cnt    <= '0;
            r_rr_ptr       <= '0;
            r_inflight     <= 1'b0;
            r_inflight_idx <= '0;
        end else if (CCUSRV_Rst) begin
            r_state        <= ST_IDLE;
            r_issue_cnt    <= '0;
            r_rr_ptr       <= '0;
            r_inflight     <= 1'b0;
            r_inflight_idx <= '0;
        end else begin
            r_state        <= w_state_next;
            r_inflight     <= w_gnt_vld;
            r_inflight_idx <= w_gnt_idx;
            if (r_state == ST_IDLE && CCUSRV_CfgVld) begin
                r_base      <= CCUSRV_CfgBase;
                r_num       <= CCUSRV_CfgNum;
                r_issue_cnt <= '0;
            end
            if (w_gnt_vld) begin
                r_issue_cnt <= w_cnt_next;
                r_rr_ptr    <= w_rr_ptr_next;
            end
        end
    end

    // The returning word lands in its core's buffer; a refill on the same edge as a drain wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ofm_vld <= '0;
            r_ofm     <= '0;
        end else if (CCUSRV_Rst) begin
            r_ofm_vld <= '0;
            r_ofm     <= '0;
        end else begin
            for (int i = 0; i < POOL_CORE; i++) begin
                if (r_inflight && (r_inflight_idx == PTR_W'(i))) begin
                    r_ofm[i]     <= SRAMSRV_RdDat;
                    r_ofm_vld[i] <= 1'b1;
                end else if (r_ofm_vld[i] && pol.OfmRdy[i]) begin
                    r_ofm_vld[i] <= 1'b0;
                end
            end
        end
    end
endmodule
